// File: rtl/ma_stage_pipelined_if.sv
// Handshake and data bundle between EX, the MA stage and RW.
// master is the EX/RW side, slave is the MA stage itself.
interface ma_stage_pipelined_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 22
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   pc_in;
  logic [31:0]       inst_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [XLEN-1:0]   alu_result;
  logic [XLEN-1:0]   op2;
  logic              fwd_sel;
  logic [XLEN-1:0]   fwd_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   pc_out;
  logic [31:0]       inst_out;
  logic [XLEN-1:0]   alu_res_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [XLEN-1:0]   ld_result;
  logic              misalign;

  modport master (
    output in_valid, pc_in, inst_in, ctrl_in, alu_result, op2, fwd_sel, fwd_data, out_ready,
    input  in_ready, out_valid, pc_out, inst_out, alu_res_out, ctrl_out, ld_result, misalign
  );

  modport slave (
    input  in_valid, pc_in, inst_in, ctrl_in, alu_result, op2, fwd_sel, fwd_data, out_ready,
    output in_ready, out_valid, pc_out, inst_out, alu_res_out, ctrl_out, ld_result, misalign
  );
endinterface

// File: rtl/ma_stage_pipelined.sv
// Registered memory-access stage: sized loads/stores against a word-organised data memory,
// with valid/ready on both sides and a fixed extra latency for memory operations.
module ma_stage_pipelined #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 1024,
  parameter int CTRL_W  = 22,
  parameter int MEM_LAT = 0
) (
  input logic                clk,
  input logic                rst,
  ma_stage_pipelined_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          state;
  logic [3:0]      wait_cnt;
  logic [XLEN-1:0] mem [DEPTH];

  logic            accept;
  logic            is_st;
  logic            is_ld;
  logic            mem_op;
  logic            mis;
  logic [2:0]      funct3;
  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic [XLEN-1:0] st_data;
  logic [XLEN-1:0] rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [XLEN-1:0] ld_val;
  logic [XLEN-1:0] wdata;
  logic [3:0]      wmask;

  // isLd together with isSt is handled as a pure store
  assign accept  = (state == IDLE) && bus.in_valid;
  assign funct3  = bus.inst_in[14:12];
  assign is_st   = bus.ctrl_in[0];
  assign is_ld   = bus.ctrl_in[1] & ~bus.ctrl_in[0];
  assign mem_op  = bus.ctrl_in[1] | bus.ctrl_in[0];
  assign idx     = bus.alu_result[AW+1:2];
  assign lane    = bus.alu_result[1:0];
  assign st_data = bus.fwd_sel ? bus.fwd_data : bus.op2;
  assign rd_word = mem[idx];
  assign rd_byte = rd_word[{lane, 3'b000} +: 8];
  assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

  assign bus.in_ready = (state == IDLE);

  // Undefined size encodings are never reported as misaligned
  always_comb begin
    mis = 1'b0;
    if (is_st) begin
      case (funct3)
        3'b001:  mis = lane[0];
        3'b010:  mis = |lane;
        default: mis = 1'b0;
      endcase
    end else if (is_ld) begin
      case (funct3)
        3'b001, 3'b101: mis = lane[0];
        3'b010:         mis = |lane;
        default:        mis = 1'b0;
      endcase
    end
  end

  always_comb begin
    wmask = 4'b0000;
    wdata = st_data;
    if (is_st && !mis) begin
      case (funct3)
        3'b000: begin
          wmask = 4'b0001 << lane;
          wdata = {4{st_data[7:0]}};
        end
        3'b001: begin
          wmask = lane[1] ? 4'b1100 : 4'b0011;
          wdata = {2{st_data[15:0]}};
        end
        3'b010:  wmask = 4'b1111;
        default: wmask = 4'b0000;
      endcase
    end
  end

  always_comb begin
    ld_val = '0;
    if (is_ld && !mis) begin
      case (funct3)
        3'b000:  ld_val = {{(XLEN-8){rd_byte[7]}}, rd_byte};
        3'b001:  ld_val = {{(XLEN-16){rd_half[15]}}, rd_half};
        3'b010:  ld_val = rd_word;
        3'b100:  ld_val = {{(XLEN-8){1'b0}}, rd_byte};
        3'b101:  ld_val = {{(XLEN-16){1'b0}}, rd_half};
        default: ld_val = '0;
      endcase
    end
  end

  // Stores commit at the accept edge, so a later load always sees them
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // wait_cnt is loaded with MEM_LAT and must drain to zero before DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      bus.out_valid   <= 1'b0;
      bus.pc_out      <= '0;
      bus.inst_out    <= '0;
      bus.alu_res_out <= '0;
      bus.ctrl_out    <= '0;
      bus.ld_result   <= '0;
      bus.misalign    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bus.pc_out      <= bus.pc_in;
            bus.inst_out    <= bus.inst_in;
            bus.alu_res_out <= bus.alu_result;
            bus.ctrl_out    <= bus.ctrl_in;
            bus.ld_result   <= ld_val;
            bus.misalign    <= mis;
            if (mem_op && (MEM_LAT > 0)) begin
              state    <= WAIT;
              wait_cnt <= 4'(MEM_LAT);
            end else begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ma_stage_pipelined.sv
// Scoreboard bench for ma_stage_pipelined: expected results queued at issue, compared on out_valid.
module tb_ma_stage_pipelined;
  localparam int XLEN    = 32;
  localparam int DEPTH   = 1024;
  localparam int CTRL_W  = 22;
  localparam int MEM_LAT = 3;
  localparam int MEM_EDGES = 1 + MEM_LAT;
  localparam logic [1:0] K_ALU  = 2'b00;
  localparam logic [1:0] K_ST   = 2'b01;
  localparam logic [1:0] K_LD   = 2'b10;
  localparam logic [1:0] K_LDST = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ma_stage_pipelined_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus();

  ma_stage_pipelined #(
    .XLEN(XLEN), .DEPTH(DEPTH), .CTRL_W(CTRL_W), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]       pc;
    logic [31:0]       inst;
    logic [31:0]       alu;
    logic [31:0]       ld;
    logic [CTRL_W-1:0] ctrl;
    logic              mis;
  } exp_t;

  exp_t sb[$];
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic [CTRL_W-1:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] op2, input logic fs,
                       input logic [31:0] fd);
    int n;
    @(negedge clk);
    bus.pc_in      = pc;
    bus.inst_in    = inst;
    bus.ctrl_in    = ctrl;
    bus.alu_result = addr;
    bus.op2        = op2;
    bus.fwd_sel    = fs;
    bus.fwd_data   = fd;
    bus.in_valid   = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL accept_timeout: in_ready=%b want 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input string name, input int exp_lat, input int hold);
    exp_t e;
    int n;
    bit ready_seen;
    e = sb.pop_front();
    n = 0;
    ready_seen = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (bus.in_ready !== 1'b0) ready_seen = 1;
    end while (bus.out_valid !== 1'b1 && n < 40);
    tests_run++;
    if (n != exp_lat || bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s latency: got %0d edges (out_valid=%b) want %0d", name, n, bus.out_valid, exp_lat);
    end
    tests_run++;
    if (ready_seen) begin
      tests_failed++;
      $display("[TB] FAIL %s busy_ready: in_ready got 1 want 0 while busy", name);
    end
    tests_run++;
    if (bus.ld_result !== e.ld) begin
      tests_failed++;
      $display("[TB] FAIL %s ld_result: got %h want %h", name, bus.ld_result, e.ld);
    end
    tests_run++;
    if (bus.misalign !== e.mis) begin
      tests_failed++;
      $display("[TB] FAIL %s misalign: got %b want %b", name, bus.misalign, e.mis);
    end
    tests_run++;
    if (bus.alu_res_out !== e.alu || bus.pc_out !== e.pc || bus.inst_out !== e.inst || bus.ctrl_out !== e.ctrl) begin
      tests_failed++;
      $display("[TB] FAIL %s passthru: got alu=%h pc=%h inst=%h ctrl=%h want alu=%h pc=%h inst=%h ctrl=%h",
               name, bus.alu_res_out, bus.pc_out, bus.inst_out, bus.ctrl_out, e.alu, e.pc, e.inst, e.ctrl);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.ld_result !== e.ld || bus.alu_res_out !== e.alu) begin
        tests_failed++;
        $display("[TB] FAIL %s stall%0d: got v=%b r=%b ld=%h alu=%h want v=1 r=0 ld=%h alu=%h",
                 name, i, bus.out_valid, bus.in_ready, bus.ld_result, bus.alu_res_out, e.ld, e.alu);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s release: got v=%b r=%b want v=0 r=1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic run(input string name, input logic [2:0] f3, input logic [1:0] kind,
                     input logic [31:0] addr, input logic [31:0] op2, input logic fs,
                     input logic [31:0] fd, input logic [31:0] exp_ld, input logic exp_mis,
                     input int hold);
    exp_t e;
    e.pc   = $urandom;
    e.inst = {17'($urandom), f3, 12'($urandom)};
    e.ctrl = CTRL_W'($urandom);
    e.ctrl[1:0] = kind;
    e.alu  = addr;
    e.ld   = exp_ld;
    e.mis  = exp_mis;
    sb.push_back(e);
    drive(e.pc, e.inst, e.ctrl, addr, op2, fs, fd);
    collect(name, (kind != K_ALU) ? MEM_EDGES : 1, hold);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.ld_result !== '0 || bus.misalign !== 1'b0 ||
        bus.pc_out !== '0 || bus.alu_res_out !== '0 || bus.ctrl_out !== '0 || bus.inst_out !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got v=%b r=%b ld=%h mis=%b pc=%h alu=%h want v=0 r=1 all zero",
               bus.out_valid, bus.in_ready, bus.ld_result, bus.misalign, bus.pc_out, bus.alu_res_out);
    end
  endtask

  task automatic test_word_load_store();
    run("sw_40",  3'b010, K_ST, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    run("lw_40",  3'b010, K_LD, 32'h40, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    run("lb_43",  3'b000, K_LD, 32'h43, 32'h0, 1'b0, 32'h0, 32'hFFFFFFDE, 1'b0, 0);
    run("lbu_43", 3'b100, K_LD, 32'h43, 32'h0, 1'b0, 32'h0, 32'h000000DE, 1'b0, 0);
  endtask

  task automatic test_byte_fwd();
    run("sb_fwd_41", 3'b000, K_ST, 32'h41, 32'h11, 1'b1, 32'h7F, 32'h0, 1'b0, 0);
    run("lw_40_sb",  3'b010, K_LD, 32'h40, 32'h0, 1'b0, 32'h0, 32'hDEAD7FEF, 1'b0, 0);
    run("lh_42",     3'b001, K_LD, 32'h42, 32'h0, 1'b0, 32'h0, 32'hFFFFDEAD, 1'b0, 0);
    run("lhu_40",    3'b101, K_LD, 32'h40, 32'h0, 1'b0, 32'h0, 32'h00007FEF, 1'b0, 0);
  endtask

  task automatic test_misalign();
    run("sh_41_mis",  3'b001, K_ST, 32'h41, 32'hAAAA, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    run("lw_42_mis",  3'b010, K_LD, 32'h42, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 0);
    run("st_undef",   3'b011, K_ST, 32'h40, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    run("ld_undef",   3'b011, K_LD, 32'h40, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    run("lw_40_kept", 3'b010, K_LD, 32'h40, 32'h0, 1'b0, 32'h0, 32'hDEAD7FEF, 1'b0, 0);
    run("ldst_80",    3'b010, K_LDST, 32'h80, 32'h12345678, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    run("lw_80",      3'b010, K_LD, 32'h80, 32'h0, 1'b0, 32'h0, 32'h12345678, 1'b0, 0);
  endtask

  task automatic test_latency_stall();
    run("lw_stall", 3'b010, K_LD, 32'h40, 32'h0, 1'b0, 32'h0, 32'hDEAD7FEF, 1'b0, 5);
  endtask

  task automatic test_alu_alias();
    run("alu_1234",   3'b001, K_ALU, 32'h1234, 32'h55, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    run("alu_odd",    3'b010, K_ALU, 32'h1235, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2);
    run("sw_alias",   3'b010, K_ST, 32'(4*DEPTH + 8), 32'hCAFEF00D, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    run("lw_8_alias", 3'b010, K_LD, 32'h8, 32'h0, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] data [4];
    for (int i = 0; i < 4; i++) begin
      data[i] = $urandom;
      run("b2b_sw", 3'b010, K_ST, 32'h200 + 32'(4*i), data[i], 1'b0, 32'h0, 32'h0, 1'b0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      run("b2b_lw", 3'b010, K_LD, 32'h200 + 32'(4*i), 32'h0, 1'b0, 32'h0, data[i], 1'b0, 0);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit woke;
    drive(32'h1000, 32'h0000_2023, 22'h3FFF01, 32'h100, 32'h0BADC0DE, 1'b0, 32'h0);
    tests_run++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_pre_wait: got r=%b v=%b want r=0 v=0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.pc_out !== '0 || bus.alu_res_out !== '0 ||
        bus.ctrl_out !== '0 || bus.inst_out !== '0 || bus.ld_result !== '0 || bus.misalign !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rst_mid_wait: got v=%b r=%b pc=%h alu=%h ctrl=%h want v=0 r=1 all zero",
               bus.out_valid, bus.in_ready, bus.pc_out, bus.alu_res_out, bus.ctrl_out);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    woke = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) woke = 1;
    end
    tests_run++;
    if (woke) begin
      tests_failed++;
      $display("[TB] FAIL rst_dropped: out_valid got 1 want 0 after reset");
    end
    run("lw_100_kept", 3'b010, K_LD, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0BADC0DE, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.pc_in      = '0;
    bus.inst_in    = '0;
    bus.ctrl_in    = '0;
    bus.alu_result = '0;
    bus.op2        = '0;
    bus.fwd_sel    = 1'b0;
    bus.fwd_data   = '0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_word_load_store();
    test_byte_fwd();
    test_misalign();
    test_latency_stall();
    test_alu_alias();
    test_back_to_back();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
